mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameters: MB_SIZE=4, block edge in pixels; REF_FRAME_SIZE=8, reference window edge; NUM_BLOCKS=16, blocks per frame; LATENCY=2, motion-compensation datapath cycles from stable MV to valid residual.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that begins a frame; ignored unless state is IDLE.
REQ-005 mv_valid  in  1; mv_ready  out  1  MV input handshake.
REQ-006 mv_x_in, mv_y_in  in  6 each  unsigned candidate motion vector.
REQ-007 mc_mv_x, mc_mv_y  out  6 each  registered MV driven to the motion-compensation datapath.
REQ-008 res_valid  out  1; res_ready  in  1  residual output handshake.
REQ-009 res_blk_idx  out  $clog2(NUM_BLOCKS)  index of the block whose residual is presented.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle pulse after the last block is accepted.
REQ-012 mv_clamped  out  1  one-cycle pulse when a captured MV was modified (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, WAIT_MV, RUN, OUT and DONE.
REQ-014 IDLE: on start=1, go to WAIT_MV and set blk_cnt=0.
REQ-015 WAIT_MV: mv_ready=1; on mv_valid&mv_ready, register the MV into mc_mv_x/y, set lat_cnt=0 and go to RUN.
REQ-016 mv_ready SHALL be 0 in every state except WAIT_MV.
REQ-017 RUN: lat_cnt increments each cycle; when lat_cnt==LATENCY-1, go to OUT, so exactly LATENCY cycles are spent in RUN.
REQ-018 OUT: res_valid=1 and res_blk_idx=blk_cnt; both SHALL hold until res_ready=1.
REQ-019 On res_valid&res_ready with blk_cnt<NUM_BLOCKS-1: increment blk_cnt and go to WAIT_MV.
REQ-020 On res_valid&res_ready with blk_cnt==NUM_BLOCKS-1: go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, then go to IDLE; a start in the DONE cycle is ignored.
REQ-022 mc_mv_x/y SHALL change only on an MV handshake and SHALL remain stable through RUN and OUT.
REQ-023 Minimum per-block period is 1 (handshake) + LATENCY + 1 (OUT with res_ready=1) = 4 cycles at defaults.
REQ-024 A start while busy=1 SHALL have no effect.

Reset
REQ-025 While reset=1: state=IDLE, blk_cnt=0, lat_cnt=0, and mc_mv_x, mc_mv_y, mv_ready, res_valid, res_blk_idx, busy, done and mv_clamped all 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame immediately, without a done pulse; the next frame requires a new start.

Configuration
REQ-027 Macro MC_SEQ_MV_CLAMP_EN.
REQ-028 Defined: each captured MV component SHALL be saturated to the range [0, REF_FRAME_SIZE-MB_SIZE], i.e. 0..4 at defaults, so that every fetch stays inside the reference window.
REQ-029 Defined: mv_clamped SHALL pulse in the cycle after the handshake if either MV component was saturated.
REQ-030 Undefined: MVs SHALL pass through unmodified and mv_clamped SHALL be tied to 0.

Verification
REQ-031 Reset, then start, then 16 MVs with res_ready=1 permanently: res_blk_idx runs 0..15, each res_valid follows its MV handshake by 3 cycles, done pulses once, busy falls with done.
REQ-032 Backpressure: res_ready=0 for 5 cycles on block 3: res_valid, res_blk_idx=3 and mc_mv held for all 5 cycles, and mv_ready=0 throughout.
REQ-033 Clamp enabled, MV (7,2): mc_mv=(4,2) and mv_clamped pulses; clamp disabled, MV (7,2): mc_mv=(7,2) and mv_clamped=0.
REQ-034 start pulsed during block 5 and again in the DONE cycle: no effect, and the frame still completes 16 blocks.
REQ-035 reset asserted in RUN of block 9: all outputs 0 asynchronously; a new start restarts at res_blk_idx=0.
REQ-036 mv_valid=0 for 10 cycles in WAIT_MV: FSM holds in WAIT_MV with mv_ready=1 and res_valid=0.

Source files
------------

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - per-block motion-compensation sequencer: MV capture, latency wait, residual handshake.
// Optional MV saturation into the reference window is enabled by defining MC_SEQ_MV_CLAMP_EN.
module mc_sequencer #(
  parameter int MB_SIZE        = 4,
  parameter int REF_FRAME_SIZE = 8,
  parameter int NUM_BLOCKS     = 16,
  parameter int LATENCY        = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mv_valid,
  output logic                          mv_ready,
  input  logic [5:0]                    mv_x_in,
  input  logic [5:0]                    mv_y_in,
  output logic [5:0]                    mc_mv_x,
  output logic [5:0]                    mc_mv_y,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(NUM_BLOCKS)-1:0] res_blk_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          mv_clamped
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_BLK = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);

  if (REF_FRAME_SIZE < MB_SIZE || LATENCY < 1) begin : g_bad_cfg
    $error("mc_sequencer: reference window smaller than block, or zero latency");
  end

  typedef enum logic [2:0] {IDLE, WAIT_MV, RUN, OUT, DONE} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] blk_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [5:0]       cap_x, cap_y;
  logic             mv_hs;

  assign mv_hs       = mv_ready && mv_valid;
  assign res_blk_idx = blk_cnt;

`ifdef MC_SEQ_MV_CLAMP_EN
  localparam logic [5:0] MV_MAX = 6'(REF_FRAME_SIZE - MB_SIZE);
  logic cap_clamped;

  always_comb begin
    cap_x       = (mv_x_in > MV_MAX) ? MV_MAX : mv_x_in;
    cap_y       = (mv_y_in > MV_MAX) ? MV_MAX : mv_y_in;
    cap_clamped = (mv_x_in > MV_MAX) || (mv_y_in > MV_MAX);
  end

  // Pulse lands in the cycle after the handshake, alongside the new mc_mv.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mv_clamped <= 1'b0;
    else       mv_clamped <= mv_hs && cap_clamped;
  end
`else
  assign cap_x      = mv_x_in;
  assign cap_y      = mv_y_in;
  assign mv_clamped = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    mv_ready   = 1'b0;
    res_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) next_state = WAIT_MV;
      WAIT_MV: begin
        mv_ready = 1'b1;
        if (mv_valid) next_state = RUN;
      end
      RUN:     if (lat_cnt == LAT_LAST) next_state = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) next_state = (blk_cnt == LAST_BLK) ? DONE : WAIT_MV;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_cnt <= '0;
      lat_cnt <= '0;
      mc_mv_x <= '0;
      mc_mv_y <= '0;
    end else begin
      if (state == IDLE && start) blk_cnt <= '0;
      if (state == OUT && res_ready && blk_cnt != LAST_BLK) blk_cnt <= blk_cnt + 1'b1;
      if (mv_hs) begin
        mc_mv_x <= cap_x;
        mc_mv_y <= cap_y;
        lat_cnt <= '0;
      end else if (state == RUN) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - directed table-driven bench for mc_sequencer.
module tb_mc_sequencer;

`ifdef MC_SEQ_MV_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mv_valid = 1'b0;
  logic       mv_ready;
  logic [5:0] mv_x_in = '0, mv_y_in = '0;
  logic [5:0] mc_mv_x, mc_mv_y;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [3:0] res_blk_idx;
  logic       busy, done, mv_clamped;

  mc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_x_in(mv_x_in), .mv_y_in(mv_y_in), .mc_mv_x(mc_mv_x), .mc_mv_y(mc_mv_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_blk_idx(res_blk_idx),
    .busy(busy), .done(done), .mv_clamped(mv_clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] mx, my;     // MV presented
    int         idle;       // cycles of mv_valid=0 in WAIT_MV first
    int         stall;      // cycles of res_ready=0 in OUT
    bit         start_run;  // pulse start during RUN
    logic [5:0] px, py;     // expected mc_mv with clamp disabled
    logic [5:0] cx, cy;     // expected mc_mv with clamp enabled
    bit         clamped;    // expected mv_clamped with clamp enabled
  } vec_t;

  vec_t vec [16];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mc_mv_x"}, mc_mv_x, 0);
    chk({tag, " mc_mv_y"}, mc_mv_y, 0);
    chk({tag, " mv_ready"}, mv_ready, 0);
    chk({tag, " res_valid"}, res_valid, 0);
    chk({tag, " res_blk_idx"}, res_blk_idx, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " mv_clamped"}, mv_clamped, 0);
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("frame busy", busy, 1);
    chk("frame mv_ready", mv_ready, 1);
  endtask

  // Entered in WAIT_MV one step after a clock edge; returns the same way, after the res handshake edge.
  task automatic run_block(input int i);
    logic [5:0] ex, ey;
    ex = CLAMP ? vec[i].cx : vec[i].px;
    ey = CLAMP ? vec[i].cy : vec[i].py;
    for (int k = 0; k < vec[i].idle; k++) begin
      chk("idle mv_ready", mv_ready, 1);
      chk("idle res_valid", res_valid, 0);
      tick();
    end
    mv_valid = 1'b1;
    mv_x_in  = vec[i].mx;
    mv_y_in  = vec[i].my;
    chk("wait mv_ready", mv_ready, 1);
    tick();
    mv_valid = 1'b0;
    mv_x_in  = 6'h3f;
    mv_y_in  = 6'h3f;
    if (vec[i].start_run) start = 1'b1;
    chk("run1 mc_mv_x", mc_mv_x, ex);
    chk("run1 mc_mv_y", mc_mv_y, ey);
    chk("run1 mv_clamped", mv_clamped, CLAMP && vec[i].clamped);
    chk("run1 res_valid", res_valid, 0);
    chk("run1 mv_ready", mv_ready, 0);
    tick();
    start = 1'b0;
    chk("run2 res_valid", res_valid, 0);
    chk("run2 mv_clamped", mv_clamped, 0);
    if (vec[i].stall > 0) res_ready = 1'b0;
    tick();
    for (int k = 0; k < vec[i].stall; k++) begin
      chk("stall res_valid", res_valid, 1);
      chk("stall res_blk_idx", res_blk_idx, i);
      chk("stall mc_mv_x", mc_mv_x, ex);
      chk("stall mc_mv_y", mc_mv_y, ey);
      chk("stall mv_ready", mv_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    chk("out res_valid", res_valid, 1);
    chk("out res_blk_idx", res_blk_idx, i);
    chk("out mc_mv_x", mc_mv_x, ex);
    chk("out done", done, 0);
    tick();
  endtask

  initial begin
    //               mx  my  idle stall st  px  py  cx  cy  clamped
    vec[0]  = '{6'd7,  6'd2, 0, 0, 0, 6'd7,  6'd2, 6'd4, 6'd2, 1};
    vec[1]  = '{6'd0,  6'd0, 0, 0, 0, 6'd0,  6'd0, 6'd0, 6'd0, 0};
    vec[2]  = '{6'd1,  6'd3, 10, 0, 0, 6'd1, 6'd3, 6'd1, 6'd3, 0};
    vec[3]  = '{6'd3,  6'd4, 0, 5, 0, 6'd3,  6'd4, 6'd3, 6'd4, 0};
    vec[4]  = '{6'd2,  6'd5, 0, 0, 0, 6'd2,  6'd5, 6'd2, 6'd4, 1};
    vec[5]  = '{6'd4,  6'd1, 0, 0, 1, 6'd4,  6'd1, 6'd4, 6'd1, 0};
    vec[6]  = '{6'd1,  6'd1, 0, 0, 0, 6'd1,  6'd1, 6'd1, 6'd1, 0};
    vec[7]  = '{6'd63, 6'd5, 0, 0, 0, 6'd63, 6'd5, 6'd4, 6'd4, 1};
    vec[8]  = '{6'd2,  6'd2, 0, 0, 0, 6'd2,  6'd2, 6'd2, 6'd2, 0};
    vec[9]  = '{6'd6,  6'd1, 0, 0, 0, 6'd6,  6'd1, 6'd4, 6'd1, 1};
    vec[10] = '{6'd4,  6'd4, 0, 0, 0, 6'd4,  6'd4, 6'd4, 6'd4, 0};
    vec[11] = '{6'd5,  6'd0, 0, 0, 0, 6'd5,  6'd0, 6'd4, 6'd0, 1};
    vec[12] = '{6'd0,  6'd32, 0, 0, 0, 6'd0, 6'd32, 6'd0, 6'd4, 1};
    vec[13] = '{6'd3,  6'd3, 0, 0, 0, 6'd3,  6'd3, 6'd3, 6'd3, 0};
    vec[14] = '{6'd0,  6'd4, 0, 0, 0, 6'd0,  6'd4, 6'd0, 6'd4, 0};
    vec[15] = '{6'd9,  6'd9, 0, 0, 0, 6'd9,  6'd9, 6'd4, 6'd4, 1};

    #12;
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk("idle busy", busy, 0);
    chk("idle mv_ready", mv_ready, 0);

    // Full frame: idle wait, backpressure and a start pulse while busy are all in the table.
    start_frame();
    for (int i = 0; i < 16; i++) run_block(i);
    chk("done pulse", done, 1);
    chk("done busy", busy, 1);
    chk("done res_valid", res_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("after done", done, 0);
    chk("after busy", busy, 0);
    tick();
    chk("start in DONE ignored busy", busy, 0);
    chk("start in DONE ignored mv_ready", mv_ready, 0);

    // Second frame: reset asserted during RUN of block 9.
    start_frame();
    for (int i = 0; i < 9; i++) run_block(i);
    mv_valid = 1'b1;
    mv_x_in  = vec[9].mx;
    mv_y_in  = vec[9].my;
    tick();
    mv_valid = 1'b0;
    chk("blk9 mc_mv_x", mc_mv_x, CLAMP ? vec[9].cx : vec[9].px);
    #2 reset = 1'b1;
    #1 chk_zero("async reset");
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post reset busy", busy, 0);
    chk("post reset done", done, 0);
    start_frame();
    run_block(0);
    chk("restart busy", busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
